md_handover_ctrl: RTL

Mobile-device handover decision stage. It consumes the per-station signal qualities and the demuxed downlink data, and it drives the target and quality reports back to the DM stage. It selects the serving base station and applies hysteresis plus time-to-trigger before commanding a handover. It freezes the delivered data during a fixed handover guard window.

---
 rtl/md_handover_ctrl_if.sv | 26 ++
 rtl/md_handover_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/md_handover_ctrl_if.sv
// Bus between the DM stage and the handover decision stage.
// master = DM side (drives qualities/strobe/data), slave = handover controller.
interface md_handover_ctrl_if;
   logic [7:0] signalquality1;
   logic [7:0] signalquality2;
   logic [7:0] signalquality3;
   logic       compare_enable;
   logic [3:0] DM_MD_data;
   logic [3:0] final_data;
   logic [1:0] MD_DM_target;
   logic [7:0] MD_DM_sq1;
   logic [7:0] MD_DM_sq2;
   logic [7:0] MD_DM_sq3;
   logic       ho_active;
   logic [7:0] ho_count;

   modport master (
      output signalquality1, signalquality2, signalquality3, compare_enable, DM_MD_data,
      input  final_data, MD_DM_target, MD_DM_sq1, MD_DM_sq2, MD_DM_sq3, ho_active, ho_count
   );

   modport slave (
      input  signalquality1, signalquality2, signalquality3, compare_enable, DM_MD_data,
      output final_data, MD_DM_target, MD_DM_sq1, MD_DM_sq2, MD_DM_sq3, ho_active, ho_count
   );
endinterface

// File: rtl/md_handover_ctrl.sv
// Handover decision stage: picks the serving base station, applies hysteresis
// and time-to-trigger before switching, and freezes delivered data for a fixed
// guard window while a handover is in progress.
module md_handover_ctrl #(
   parameter int HYST  = 8,
   parameter int TTT   = 3,
   parameter int GUARD = 8,
   parameter int CW    = 4
) (
   input  logic               clk,
   input  logic               reset,
   md_handover_ctrl_if.slave  bus
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] CONNECTED = 2'd1;
   localparam logic [1:0] HANDOVER  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] ttt_cnt;
   logic [CW-1:0] guard_cnt;
   logic [1:0]    cand;

   logic [1:0]    best_all;
   logic [1:0]    best_other;
   logic [7:0]    serv_q;
   logic [7:0]    other_q;
   logic          all_zero;
   logic          qualifies;
   logic [CW-1:0] ttt_next;

   // Best of all three stations; ties resolve to the lowest index.
   always_comb begin
      best_all = 2'b11;
      if (bus.signalquality1 >= bus.signalquality2 && bus.signalquality1 >= bus.signalquality3)
         best_all = 2'b01;
      else if (bus.signalquality2 >= bus.signalquality3)
         best_all = 2'b10;
      all_zero = (bus.signalquality1 == 8'd0) && (bus.signalquality2 == 8'd0) &&
                 (bus.signalquality3 == 8'd0);
   end

   // Serving quality and best non-serving candidate (lower index wins ties).
   always_comb begin
      serv_q     = 8'd0;
      other_q    = 8'd0;
      best_other = 2'b00;
      case (bus.MD_DM_target)
         2'b01: begin
            serv_q = bus.signalquality1;
            if (bus.signalquality2 >= bus.signalquality3) begin
               best_other = 2'b10; other_q = bus.signalquality2;
            end else begin
               best_other = 2'b11; other_q = bus.signalquality3;
            end
         end
         2'b10: begin
            serv_q = bus.signalquality2;
            if (bus.signalquality1 >= bus.signalquality3) begin
               best_other = 2'b01; other_q = bus.signalquality1;
            end else begin
               best_other = 2'b11; other_q = bus.signalquality3;
            end
         end
         2'b11: begin
            serv_q = bus.signalquality3;
            if (bus.signalquality1 >= bus.signalquality2) begin
               best_other = 2'b01; other_q = bus.signalquality1;
            end else begin
               best_other = 2'b10; other_q = bus.signalquality2;
            end
         end
         default: ;
      endcase
      // 9-bit compare so serv_q + HYST never wraps.
      qualifies = {1'b0, other_q} >= ({1'b0, serv_q} + 9'(HYST));
      ttt_next  = (best_other == cand) ? ttt_cnt + CW'(1) : CW'(1);
   end

   // Decision FSM, report registers and handover guard window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         ttt_cnt          <= '0;
         guard_cnt        <= '0;
         cand             <= 2'b00;
         bus.final_data   <= 4'd0;
         bus.MD_DM_target <= 2'b00;
         bus.MD_DM_sq1    <= 8'd0;
         bus.MD_DM_sq2    <= 8'd0;
         bus.MD_DM_sq3    <= 8'd0;
         bus.ho_active    <= 1'b0;
         bus.ho_count     <= 8'd0;
      end else begin
         if (bus.compare_enable) begin
            bus.MD_DM_sq1 <= bus.signalquality1;
            bus.MD_DM_sq2 <= bus.signalquality2;
            bus.MD_DM_sq3 <= bus.signalquality3;
         end
         case (state)
            IDLE: begin
               if (bus.compare_enable && !all_zero) begin
                  bus.MD_DM_target <= best_all;
                  state            <= CONNECTED;
               end
            end
            CONNECTED: begin
               bus.final_data <= bus.DM_MD_data;
               if (bus.compare_enable) begin
                  if (all_zero) begin
                     state            <= IDLE;
                     bus.MD_DM_target <= 2'b00;
                     ttt_cnt          <= '0;
                     cand             <= 2'b00;
                  end else if ((serv_q == 8'd0 && other_q != 8'd0) ||
                               (qualifies && ttt_next == CW'(TTT))) begin
                     // Link lost bypasses TTT; otherwise the candidate has won TTT samples.
                     bus.MD_DM_target <= best_other;
                     state            <= HANDOVER;
                     guard_cnt        <= '0;
                     ttt_cnt          <= '0;
                     cand             <= 2'b00;
                     bus.ho_active    <= 1'b1;
                  end else if (qualifies) begin
                     ttt_cnt <= ttt_next;
                     cand    <= best_other;
                  end else begin
                     ttt_cnt <= '0;
                     cand    <= 2'b00;
                  end
               end
            end
            HANDOVER: begin
               if (guard_cnt == CW'(GUARD - 1)) begin
                  state         <= CONNECTED;
                  bus.ho_active <= 1'b0;
                  if (bus.ho_count != 8'hFF) bus.ho_count <= bus.ho_count + 8'd1;
               end else begin
                  guard_cnt <= guard_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
